// File: rtl/period_meas_ctrl.sv
// period_meas_ctrl: arms on a rising edge of an asynchronous wave, measures
// PERIODS consecutive periods in clk cycles, and returns their average over a
// valid/ready handshake. A no-edge timeout and a software abort supervise the run.
`timescale 1ns/1ps
module period_meas_ctrl #(
    parameter int PERIODS      = 4,
    parameter int LOG2_PERIODS = 2,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT_CYC  = 50000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             wave,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             timeout
);
    localparam int ACC_W = CNT_W + LOG2_PERIODS;
    // keep k at least one bit wide so PERIODS=1 still elaborates
    localparam int K_W   = (LOG2_PERIODS > 0) ? LOG2_PERIODS : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(PERIODS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic             w_edge;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_per;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [K_W-1:0]   r_k;
    logic [CNT_W-1:0] r_result;
    logic             r_timeout;
    logic             w_acc_en;
    logic             w_close;
    logic             w_tmo_fire;

    // fixed 3-clk edge latency keeps every measured period exact
    assign w_edge     = r_s2 & ~r_s3;
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
    // cnt+1 at the closing edge equals the period; wraps only if cnt saturated
    assign w_per      = r_cnt + CNT_W'(1);
    assign w_acc_nxt  = r_acc + ACC_W'(w_per);
    // abort outranks both edge and timeout in the same cycle
    assign w_acc_en   = (r_state == S_MEAS) & w_edge & ~abort;
    assign w_close    = w_acc_en & (r_k == K_LAST);
    assign w_tmo_fire = ((r_state == S_ARM) | (r_state == S_MEAS)) & ~abort
                        & ~w_edge & (r_cnt == TO_LAST);

    assign result  = r_result;
    assign timeout = r_timeout;

    // two-flop synchronizer plus the delayed copy used for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= wave;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // next-state and handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        busy         = (r_state != S_IDLE);
        result_valid = (r_state == S_DONE);
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_ARM;
            S_ARM: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_edge)     w_state_nxt = S_MEAS;
                else if (w_tmo_fire) w_state_nxt = S_DONE;
            end
            S_MEAS: begin
                if (abort)           w_state_nxt = S_IDLE;
                else if (w_close)    w_state_nxt = S_DONE;
                else if (w_tmo_fire) w_state_nxt = S_DONE;
            end
            S_DONE: if (result_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // counter, accumulator, period index and the held result/timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_k       <= '0;
            r_result  <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_k   <= '0;
            if (start) r_timeout <= 1'b0;
        end else begin
            r_cnt <= w_edge ? '0 : w_cnt_inc;
            if (w_acc_en) begin
                r_acc <= w_acc_nxt;
                r_k   <= r_k + K_W'(1);
            end
            if (w_close) begin
                r_result  <= w_acc_nxt[ACC_W-1:LOG2_PERIODS];
                r_timeout <= 1'b0;
            end else if (w_tmo_fire) begin
                r_result  <= '0;
                r_timeout <= 1'b1;
            end
        end
    end
endmodule
